// File: rtl/cnn_conv_acc_relu.sv
// cnn_conv_acc_relu: accumulates one kernel window of products, adds bias,
// rescales with round-half-up, optional ReLU, saturates to an activation.
module cnn_conv_acc_relu #(
  parameter int PROD_W = 23,
  parameter int N_TAPS = 9,
  parameter int ACC_W  = 28,
  parameter int OUT_W  = 14,
  parameter int SHIFT  = 7,
  parameter int RELU   = 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [ACC_W-1:0]  bias,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sat
);

  localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TAPS - 1);

  localparam logic [ACC_W:0] ONE = 1;
  localparam logic signed [ACC_W:0] RND = (ONE << SHIFT) >> 1;

  localparam int OMAX_I = (1 << (OUT_W - 1)) - 1;
  localparam logic signed [ACC_W:0] OMAX = (ACC_W+1)'(OMAX_I);
  localparam logic signed [ACC_W:0] OMIN = (ACC_W+1)'(-OMAX_I - 1);

  typedef enum logic {
    S_ACC,
    S_EMIT
  } state_t;

  state_t                    state_q;
  logic [CNT_W-1:0]          tap_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [OUT_W-1:0]          out_data_q;
  logic                      out_sat_q;

  logic signed [ACC_W-1:0]   prod_x;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W:0]     s_rnd;
  logic signed [ACC_W:0]     r_sh;
  logic signed [ACC_W:0]     r_cl;
  logic [OUT_W-1:0]          out_data_d;
  logic                      out_sat_d;

  // ready only from registered state; held low while reset is asserted
  assign prod_ready = (state_q == S_ACC) && !ap_rst;
  assign out_valid  = (state_q == S_EMIT);
  assign out_data   = out_data_q;
  assign out_sat    = out_sat_q;

  // next accumulator value and the rescaled, clamped activation it yields
  always_comb begin
    prod_x = ACC_W'($signed(prod_data));
    acc_d  = ((tap_q == '0) ? $signed(bias) : acc_q) + prod_x;
    s_rnd  = {acc_d[ACC_W-1], acc_d} + RND;
    r_sh   = s_rnd >>> SHIFT;
    r_cl   = r_sh;
    out_sat_d = 1'b0;
    if (RELU != 0 && r_sh[ACC_W]) begin
      r_cl = '0;
    end
    if (r_cl > OMAX) begin
      r_cl = OMAX;
      out_sat_d = 1'b1;
    end else if (r_cl < OMIN) begin
      r_cl = OMIN;
      out_sat_d = 1'b1;
    end
    out_data_d = r_cl[OUT_W-1:0];
  end

  // window FSM: accumulate taps, then hold the result until consumed
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= S_ACC;
      tap_q      <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_ACC: begin
          if (prod_valid) begin
            acc_q <= acc_d;
            if (tap_q == LAST) begin
              tap_q      <= '0;
              out_data_q <= out_data_d;
              out_sat_q  <= out_sat_d;
              state_q    <= S_EMIT;
            end else begin
              tap_q <= tap_q + 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            state_q <= S_ACC;
          end
        end
        default: state_q <= S_ACC;
      endcase
    end
  end

endmodule
